fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of decode/read. It owns the PC and issues one instruction-memory request at a time, with at most one request outstanding. A two-entry buffer (output register plus skid) holds returned words, and the block presents `instr`/`instr_pc`/`instr_valid` to decode. It absorbs decode stalls, load-use bubbles and control-flow redirects without dropping or duplicating instructions.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
//   Owns the PC, keeps at most one instruction-memory request outstanding, and
//   buffers returned words in a two-entry store (OUT register + SKID) so decode
//   stalls, load-use bubbles and redirects never drop or duplicate a word.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall, bubble       decode holds (no consumption this cycle)
//   redirect, redirect_pc  taken control flow; new fetch target
//   imem_req/addr/ready    request handshake (accept = req && ready)
//   imem_resp_valid/rdata  response for the outstanding request
//   instr/instr_pc/instr_valid  entry presented to decode
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_2000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        bubble,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);

   localparam logic [31:0] RESET_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   // IDLE: nothing outstanding; WAIT: outstanding, keep; DROP: outstanding, discard
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, req_pc, target;
   logic        out_v, skid_v;
   logic [31:0] out_word, out_pc, skid_word, skid_pc;
   logic        advance, land, accept, credit;
   logic [2:0]  occ_nxt;

   always_comb begin
      target  = redirect_pc & 32'hFFFF_FFFC;
      advance = out_v & ~stall & ~bubble;
      // a response is only kept when it answers a live request and no redirect kills it
      land    = (state == WAIT) & imem_resp_valid & ~redirect;
      // occupancy after this edge; a new request needs a free slot for its eventual word
      occ_nxt = 3'(out_v) + 3'(skid_v) - 3'(advance) + 3'(land);
      credit  = occ_nxt < 3'd2;
      // request only when the slot frees: idle, or the outstanding one returns now
      imem_req = rst & ~redirect & (state != DROP) &
                 ((state == IDLE) | imem_resp_valid) & credit;
      accept  = imem_req & imem_ready;

      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: begin
            if (redirect)             state_nxt = imem_resp_valid ? IDLE : DROP;
            else if (imem_resp_valid) state_nxt = accept ? WAIT : IDLE;
         end
         DROP: if (imem_resp_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pc     <= RESET_ALIGNED;
         req_pc <= 32'h0;
      end else begin
         state <= state_nxt;
         if (redirect)    pc <= target;
         else if (accept) pc <= pc + 32'd4;
         // remember which address the outstanding request fetches
         if (accept) req_pc <= pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_v     <= 1'b0;
         out_word  <= 32'h0;
         out_pc    <= 32'h0;
         skid_v    <= 1'b0;
         skid_word <= 32'h0;
         skid_pc   <= 32'h0;
      end else if (redirect) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         if (advance) begin
            out_v    <= skid_v;
            out_word <= skid_word;
            out_pc   <= skid_pc;
            skid_v   <= 1'b0;
         end
         // later assignments override the shift above when a word lands
         if (land) begin
            if (!out_v || (advance && !skid_v)) begin
               out_v    <= 1'b1;
               out_word <= imem_rdata;
               out_pc   <= req_pc;
            end else begin
               skid_v    <= 1'b1;
               skid_word <= imem_rdata;
               skid_pc   <= req_pc;
            end
         end
      end
   end

   assign imem_addr   = pc;
   assign instr       = out_v ? out_word : NOP_INSTR;
   assign instr_pc    = out_pc;
   assign instr_valid = out_v;

endmodule
